xor_gate: RTL and testbench
===========================

# xor_gate

Bitwise exclusive-OR datapath primitive with a combinational result, plus a registered copy and Hamming-distance statistics for use in compare, parity and error-detection paths. The combinational output `y` must behave as a pure XOR so the block can replace a plain gate. The clocked side adds a pipelined result, per-cycle Hamming distance, parity and a saturating accumulated-difference counter for downstream monitors.

## Interface
- `WIDTH`, default 1: operand width in bits, range 1..64.
- `CNT_W`, default 16: width of the accumulated-difference counter, range 4..32.
- `clk` input 1: single clock; all registers update on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `clr` input 1: synchronous clear of `acc` and `acc_sat`; active high.
- `y` output WIDTH: combinational `a ^ b`.
- `y_q` output WIDTH: `a ^ b` registered.
- `dist_q` output clog2(WIDTH+1): registered popcount of `a ^ b`, giving the Hamming distance.
- `par_q` output 1: registered reduction XOR of `a ^ b`.
- `acc` output CNT_W: running sum of `dist_q`, saturating.
- `acc_sat` output 1: sticky flag, set when `acc` saturates.

## Operation
- `y = a ^ b`, bit for bit, with no storage. It depends only on `a` and `b` and is valid even when `clk` and `rst_n` are idle or unconnected.
- Every rising edge of `clk` with `rst_n` high:
  - `y_q` captures `a ^ b`.
  - `dist_q` captures popcount(`a ^ b`).
  - `par_q` captures the reduction XOR of `a ^ b`.
- `acc` update rule, evaluated each cycle:
  - If `clr` is high: `acc` and `acc_sat` go to 0. `clr` has priority over accumulation in the same cycle.
  - Otherwise, if `acc + dist_q` exceeds 2^CNT_W-1: `acc` holds at 2^CNT_W-1 and `acc_sat` is set to 1.
  - Otherwise: `acc` becomes `acc + dist_q`.
- `acc` accumulates the registered `dist_q`, not the live inputs. The accumulation therefore trails `dist_q` by one cycle.
- `acc_sat` is sticky. Only `clr` or reset clears it.
- Inputs are treated as 2-state. Behaviour with X or Z on `a` or `b` is undefined for the registered outputs. `y` follows normal Verilog XOR semantics.

## Timing
- `y` has zero-cycle latency: it is a combinational path from `a` and `b`.
- `y_q`, `dist_q` and `par_q` have 1-cycle latency from inputs sampled at the edge.
- `acc` reflects a given input sample 2 cycles after that sample.
- Reset values, applied asynchronously when `rst_n` falls and held while it is low: `y_q`=0, `dist_q`=0, `par_q`=0, `acc`=0, `acc_sat`=0. `y` is not affected by reset.
- Reset deassertion is synchronous to `clk`. The first capture happens on the first rising edge with `rst_n` high.
- Reset asserted mid-operation discards every registered value immediately. There is no partial update.
- There is no handshake; every cycle is a valid sample.

## Structure
- Package `xor_gate_pkg`:
  - `function automatic clog2` for sizing `dist_q`.
  - `localparam MAX_WIDTH = 64`.
  - Saturation-constant helper.
- Sub-module `popcount`, parameterised by `WIDTH`: purely combinational adder tree that returns the number of set bits. It is instantiated once on `a ^ b`.
- Top level contains:
  - The XOR assign.
  - One async-reset register bank covering `y_q`, `dist_q`, `par_q`, `acc` and `acc_sat`.
  - Saturating-add logic with a CNT_W+1-bit intermediate sum.

## Test plan
- WIDTH=1, clock idle, rst_n held low; drive a/b = 0/0, 0/1, 1/0, 1/1 at 10 ns steps -> `y` = 0, 1, 1, 0 at each step, with no clock edge required.
- WIDTH=8, a=0xF0, b=0x3C, then one edge -> `y`=0xCC immediately; after the edge `y_q`=0xCC, `dist_q`=4, `par_q`=0; `acc`=4 one edge later.
- WIDTH=8, a=0xFF, b=0x00 held for 5 edges -> `acc` sequence 0, 8, 16, 24, 32.
- CNT_W=4, WIDTH=8, a^b=0xFF held -> `acc` goes 8 then 15 (saturated); `acc_sat`=1 and stays 1 after the inputs return to equal values.
- Assert `clr` while the accumulator is saturated and a^b≠0 -> next edge `acc`=0 and `acc_sat`=0 (clr wins).
- Drop `rst_n` asynchronously mid-clock with nonzero state -> all registered outputs read 0 before the next edge; `y` still equals `a ^ b`.

Source files
------------

// File: rtl/xor_gate_pkg.sv
// Shared sizing helpers and constants for the xor_gate datapath primitive.
package xor_gate_pkg;

    localparam int MAX_WIDTH = 64;

    // Number of bits needed to hold values 0..value-1 (value >= 1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] sat_max(input int cnt_w);
        return 32'hFFFF_FFFF >> (32 - cnt_w);
    endfunction

    function automatic logic parity(input logic [MAX_WIDTH-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/xor_gate_popcount.sv
// Combinational set-bit counter built as a recursive binary adder tree.
module popcount
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]               bits,
    output logic [clog2(WIDTH+1)-1:0]      cnt
);

    localparam int OUT_W = clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign cnt = bits;
        end else begin : g_node
            localparam int LO_W = WIDTH / 2;
            localparam int HI_W = WIDTH - LO_W;

            logic [clog2(LO_W+1)-1:0] lo_cnt_s;
            logic [clog2(HI_W+1)-1:0] hi_cnt_s;

            popcount #(.WIDTH(LO_W)) u_lo (
                .bits (bits[LO_W-1:0]),
                .cnt  (lo_cnt_s)
            );

            popcount #(.WIDTH(HI_W)) u_hi (
                .bits (bits[WIDTH-1:LO_W]),
                .cnt  (hi_cnt_s)
            );

            assign cnt = OUT_W'(lo_cnt_s) + OUT_W'(hi_cnt_s);
        end
    endgenerate

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR with a registered copy, Hamming distance, parity and a
// saturating accumulated-difference counter fed from the registered distance.
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        clr,
    output logic [WIDTH-1:0]            y,
    output logic [WIDTH-1:0]            y_q,
    output logic [clog2(WIDTH+1)-1:0]   dist_q,
    output logic                        par_q,
    output logic [CNT_W-1:0]            acc,
    output logic                        acc_sat
);

    localparam int DIST_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(sat_max(CNT_W));

    logic [WIDTH-1:0]  xor_s;
    logic [DIST_W-1:0] dist_s;
    logic              par_s;
    logic [CNT_W:0]    sum_s;
    logic [CNT_W-1:0]  acc_nxt_s;
    logic              sat_nxt_s;

    // y stays a pure gate so the block can stand in for a plain XOR.
    assign xor_s = a ^ b;
    assign y     = xor_s;
    assign par_s = parity(MAX_WIDTH'(xor_s));

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits (xor_s),
        .cnt  (dist_s)
    );

    // Saturating add of the registered distance into the accumulator.
    always_comb begin
        sum_s     = {1'b0, acc} + (CNT_W+1)'(dist_q);
        acc_nxt_s = acc;
        sat_nxt_s = acc_sat;
        if (sum_s > {1'b0, ACC_MAX}) begin
            acc_nxt_s = ACC_MAX;
            sat_nxt_s = 1'b1;
        end else begin
            acc_nxt_s = sum_s[CNT_W-1:0];
            sat_nxt_s = acc_sat;
        end
    end

    // Register bank for all clocked outputs; clr outranks accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= {WIDTH{1'b0}};
            dist_q  <= {DIST_W{1'b0}};
            par_q   <= 1'b0;
            acc     <= {CNT_W{1'b0}};
            acc_sat <= 1'b0;
        end else begin
            y_q    <= xor_s;
            dist_q <= dist_s;
            par_q  <= par_s;
            if (clr) begin
                acc     <= {CNT_W{1'b0}};
                acc_sat <= 1'b0;
            end else begin
                acc     <= acc_nxt_s;
                acc_sat <= sat_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_xor_gate.sv
// Directed self-checking bench for xor_gate across three parameterisations.
module tb_xor_gate;

    logic clk;
    logic rst_n;

    logic [0:0]  a1, b1, y1, yq1, dq1;
    logic        clr1, pq1, sat1;
    logic [15:0] acc1;

    logic [7:0]  a8, b8, y8, yq8;
    logic [3:0]  dq8;
    logic        clr8, pq8, sat8;
    logic [15:0] acc8;

    logic [7:0]  as4, bs4, ys4, yqs4;
    logic [3:0]  dqs4;
    logic        clrs4, pqs4, sats4;
    logic [3:0]  accs4;

    int checks;
    int errors;

    xor_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr1),
        .y(y1), .y_q(yq1), .dist_q(dq1), .par_q(pq1), .acc(acc1), .acc_sat(sat1)
    );

    xor_gate #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .clr(clr8),
        .y(y8), .y_q(yq8), .dist_q(dq8), .par_q(pq8), .acc(acc8), .acc_sat(sat8)
    );

    xor_gate #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(as4), .b(bs4), .clr(clrs4),
        .y(ys4), .y_q(yqs4), .dist_q(dqs4), .par_q(pqs4), .acc(accs4), .acc_sat(sats4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full clock period; returns with clk low, 5 time units after the edge.
    task automatic cycle();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    logic [1:0] exp_y1 [4];
    logic [3:0] exp_acc8 [5];

    initial begin
        checks = 0;
        errors = 0;
        exp_y1   = '{2'd0, 2'd1, 2'd1, 2'd0};
        exp_acc8 = '{4'd0, 4'd8, 4'd0, 4'd0, 4'd0};
        clk = 1'b0; rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; clr8 = 1'b0;
        as4 = 8'h00; bs4 = 8'h00; clrs4 = 1'b0;
        #10;

        // Combinational truth table with clock idle and reset held.
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #10;
            check($sformatf("w1_y_%0d", i), 64'(y1), 64'(exp_y1[i][0]));
        end
        check("rst_yq", 64'(yq8), 64'h0);
        check("rst_dist", 64'(dq8), 64'h0);
        check("rst_par", 64'(pq8), 64'h0);
        check("rst_acc", 64'(acc8), 64'h0);
        check("rst_sat", 64'(sat8), 64'h0);

        rst_n = 1'b1;
        #5;

        a8 = 8'hF0; b8 = 8'h3C;
        #1;
        check("y_cc_comb", 64'(y8), 64'hCC);
        cycle();
        check("yq_cc", 64'(yq8), 64'hCC);
        check("dist_cc", 64'(dq8), 64'd4);
        check("par_cc", 64'(pq8), 64'd0);
        check("acc_cc_e1", 64'(acc8), 64'd0);
        cycle();
        check("acc_cc_e2", 64'(acc8), 64'd4);

        a8 = 8'h07; b8 = 8'h00;
        cycle();
        check("yq_07", 64'(yq8), 64'h07);
        check("dist_07", 64'(dq8), 64'd3);
        check("par_07", 64'(pq8), 64'd1);
        check("acc_07", 64'(acc8), 64'd8);

        // Fresh state, then a constant distance of 8 per cycle.
        rst_n = 1'b0; #2; rst_n = 1'b1; #2;
        a8 = 8'hFF; b8 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("acc_ramp_%0d", i), 64'(acc8), 64'(i * 8));
        end
        check("dist_ff", 64'(dq8), 64'd8);

        as4 = 8'hFF; bs4 = 8'h00;
        cycle();
        check("sat_acc_e1", 64'(accs4), 64'd0);
        cycle();
        check("sat_acc_e2", 64'(accs4), 64'd8);
        check("sat_flag_e2", 64'(sats4), 64'd0);
        cycle();
        check("sat_acc_e3", 64'(accs4), 64'd15);
        check("sat_flag_e3", 64'(sats4), 64'd1);
        as4 = 8'h5A; bs4 = 8'h5A;
        cycle();
        cycle();
        check("sat_hold_dist", 64'(dqs4), 64'd0);
        check("sat_hold_acc", 64'(accs4), 64'd15);
        check("sat_sticky", 64'(sats4), 64'd1);

        as4 = 8'hFF; bs4 = 8'h00;
        cycle();
        clrs4 = 1'b1;
        cycle();
        clrs4 = 1'b0;
        check("clr_acc", 64'(accs4), 64'd0);
        check("clr_sat", 64'(sats4), 64'd0);
        check("clr_dist", 64'(dqs4), 64'd8);
        cycle();
        check("post_clr_acc", 64'(accs4), 64'd8);

        // Async reset arriving while clk is high.
        clk = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_yq", 64'(yq8), 64'h0);
        check("arst_dist", 64'(dq8), 64'h0);
        check("arst_par", 64'(pqs4), 64'h0);
        check("arst_acc8", 64'(acc8), 64'h0);
        check("arst_acc4", 64'(accs4), 64'h0);
        check("arst_sat", 64'(sats4), 64'h0);
        check("arst_y", 64'(y8), 64'hFF);
        #2;
        clk = 1'b0;
        #5;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
